// File: rtl/ddr3_arb_pkg.sv
// Shared types and the round-robin pick helper for the DDR3 Avalon-MM arbiter.
// Up to four requesters are supported, so ids are always two bits wide.
package ddr3_arb_pkg;

    localparam int TAG_BURST_W = 3;
    localparam int MAX_MASTERS = 4;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        WR_LOCK = 1'b1
    } state_t;

    typedef struct packed {
        logic [1:0]             id;
        logic [TAG_BURST_W-1:0] burst;
    } rd_tag_t;

    // Bits of req above NUM_MASTERS are always zero, so scanning modulo 4
    // visits the real requesters in the same order as scanning modulo N.
    function automatic logic [1:0] rr_pick(input logic [MAX_MASTERS-1:0] req,
                                           input logic [1:0] ptr);
        logic [1:0] pick;
        logic       found;
        logic [1:0] idx;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < MAX_MASTERS; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/ddr3_arb_rd_fifo.sv
// Tracking FIFO of outstanding read commands: which master issued each read
// and how many beats it expects back.
module ddr3_arb_rd_fifo
    import ddr3_arb_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    push,
    input  rd_tag_t din,
    input  logic    pop,
    output rd_tag_t head,
    output logic    full,
    output logic    empty
);

    localparam int AW = $clog2(DEPTH);

    rd_tag_t       mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ddr3_avmm_arbiter.sv
// Round-robin arbiter sharing one DDR3 Avalon-MM local port among NUM_MASTERS
// requesters; write bursts hold the grant, read beats are routed back by tag.
module ddr3_avmm_arbiter
    import ddr3_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 25,
    parameter int DATA_W      = 64,
    parameter int BURST_W     = TAG_BURST_W,
    parameter int MAX_OUTST   = 8
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_MASTERS-1:0][ADDR_W-1:0]      m_address,
    input  logic [NUM_MASTERS-1:0]                  m_read,
    input  logic [NUM_MASTERS-1:0]                  m_write,
    input  logic [NUM_MASTERS-1:0][DATA_W-1:0]      m_writedata,
    input  logic [NUM_MASTERS-1:0][DATA_W/8-1:0]    m_byteenable,
    input  logic [NUM_MASTERS-1:0][BURST_W-1:0]     m_burstcount,
    output logic [NUM_MASTERS-1:0]                  m_waitrequest,
    output logic [NUM_MASTERS-1:0][DATA_W-1:0]      m_readdata,
    output logic [NUM_MASTERS-1:0]                  m_readdatavalid,
    output logic [ADDR_W-1:0]                       s_address,
    output logic                                    s_read,
    output logic                                    s_write,
    output logic [DATA_W-1:0]                       s_writedata,
    output logic [DATA_W/8-1:0]                     s_byteenable,
    output logic [BURST_W-1:0]                      s_burstcount,
    input  logic                                    s_waitrequest,
    input  logic [DATA_W-1:0]                       s_readdata,
    input  logic                                    s_readdatavalid,
    output logic                                    err_unexp_rdv,
    output state_t                                  arb_state
);

    state_t                 state;
    logic [1:0]             rr_ptr;
    logic [1:0]             lock_id;
    logic [BURST_W-1:0]     beats_left;
    logic [TAG_BURST_W-1:0] rd_beats;

    logic [MAX_MASTERS-1:0] req;
    logic                   req_any;
    logic [1:0]             gid;
    logic                   granted;
    logic                   sel_read;
    logic                   sel_write;
    logic [BURST_W-1:0]     sel_burst;
    logic [BURST_W-1:0]     burst_eff;
    logic                   cmd_acc;
    logic [1:0]             next_ptr;

    logic    fifo_full;
    logic    fifo_empty;
    logic    fifo_push;
    logic    fifo_pop;
    rd_tag_t push_tag;
    rd_tag_t head;
    logic    rdv_hit;
    logic    last_beat;

    assign arb_state = state;

    // Reads drop out of arbitration while the tracking FIFO is full.
    always_comb begin
        req = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            req[i] = m_write[i] || (m_read[i] && !fifo_full);
        end
    end

    assign req_any = |req;

    always_comb begin
        gid = rr_pick(req, rr_ptr);
        if (state == WR_LOCK) begin
            gid = lock_id;
        end
    end

    always_comb begin
        sel_read     = 1'b0;
        sel_write    = 1'b0;
        sel_burst    = '0;
        s_address    = '0;
        s_writedata  = '0;
        s_byteenable = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (gid == 2'(i)) begin
                sel_read     = m_read[i];
                sel_write    = m_write[i];
                sel_burst    = m_burstcount[i];
                s_address    = m_address[i];
                s_writedata  = m_writedata[i];
                s_byteenable = m_byteenable[i];
            end
        end
    end

    assign s_burstcount = sel_burst;
    assign burst_eff    = (sel_burst == '0) ? BURST_W'(1) : sel_burst;

    // Strobes are gated by reset so the port goes quiet the moment reset rises.
    assign granted = !reset && ((state == WR_LOCK) || req_any);
    assign s_write = !reset && sel_write;
    assign s_read  = !reset && (state == IDLE) && sel_read && !sel_write && !fifo_full;
    assign cmd_acc = (s_read || s_write) && !s_waitrequest;

    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            m_waitrequest[i] = (granted && gid == 2'(i)) ? s_waitrequest : 1'b1;
        end
    end

    assign next_ptr = (gid == 2'(NUM_MASTERS - 1)) ? 2'd0 : gid + 2'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            lock_id    <= '0;
            beats_left <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_acc) begin
                        rr_ptr <= next_ptr;
                        if (s_write && burst_eff > BURST_W'(1)) begin
                            state      <= WR_LOCK;
                            lock_id    <= gid;
                            beats_left <= burst_eff - 1'b1;
                        end
                    end
                end
                WR_LOCK: begin
                    if (cmd_acc) begin
                        beats_left <= beats_left - 1'b1;
                        if (beats_left == BURST_W'(1)) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign fifo_push      = s_read && !s_waitrequest;
    assign push_tag.id    = gid;
    assign push_tag.burst = TAG_BURST_W'(burst_eff);

    assign rdv_hit   = s_readdatavalid && !fifo_empty;
    assign last_beat = (rd_beats == head.burst - 1'b1);
    assign fifo_pop  = rdv_hit && last_beat;

    ddr3_arb_rd_fifo #(
        .DEPTH (MAX_OUTST)
    ) u_rd_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .din   (push_tag),
        .pop   (fifo_pop),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            m_readdata[i]      = s_readdata;
            m_readdatavalid[i] = rdv_hit && (head.id == 2'(i));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_beats      <= '0;
            err_unexp_rdv <= 1'b0;
        end else begin
            if (rdv_hit) begin
                rd_beats <= last_beat ? '0 : rd_beats + 1'b1;
            end
            if (s_readdatavalid && fifo_empty) begin
                err_unexp_rdv <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ddr3_avmm_arbiter.sv
// Directed bench for ddr3_avmm_arbiter with two requesters.
module tb_ddr3_avmm_arbiter;
    import ddr3_arb_pkg::*;

    localparam int N = 2;
    localparam int AW = 25;
    localparam int DW = 64;
    localparam int BW = 3;

    logic                  clk;
    logic                  reset;
    logic [N-1:0][AW-1:0]  m_address;
    logic [N-1:0]          m_read;
    logic [N-1:0]          m_write;
    logic [N-1:0][DW-1:0]  m_writedata;
    logic [N-1:0][DW/8-1:0] m_byteenable;
    logic [N-1:0][BW-1:0]  m_burstcount;
    logic [N-1:0]          m_waitrequest;
    logic [N-1:0][DW-1:0]  m_readdata;
    logic [N-1:0]          m_readdatavalid;
    logic [AW-1:0]         s_address;
    logic                  s_read;
    logic                  s_write;
    logic [DW-1:0]         s_writedata;
    logic [DW/8-1:0]       s_byteenable;
    logic [BW-1:0]         s_burstcount;
    logic                  s_waitrequest;
    logic [DW-1:0]         s_readdata;
    logic                  s_readdatavalid;
    logic                  err_unexp_rdv;
    state_t                arb_state;

    int n_pass  = 0;
    int n_total = 0;

    ddr3_avmm_arbiter #(
        .NUM_MASTERS (N),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .BURST_W     (BW),
        .MAX_OUTST   (8)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .m_address       (m_address),
        .m_read          (m_read),
        .m_write         (m_write),
        .m_writedata     (m_writedata),
        .m_byteenable    (m_byteenable),
        .m_burstcount    (m_burstcount),
        .m_waitrequest   (m_waitrequest),
        .m_readdata      (m_readdata),
        .m_readdatavalid (m_readdatavalid),
        .s_address       (s_address),
        .s_read          (s_read),
        .s_write         (s_write),
        .s_writedata     (s_writedata),
        .s_byteenable    (s_byteenable),
        .s_burstcount    (s_burstcount),
        .s_waitrequest   (s_waitrequest),
        .s_readdata      (s_readdata),
        .s_readdatavalid (s_readdatavalid),
        .err_unexp_rdv   (err_unexp_rdv),
        .arb_state       (arb_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m_address       = '0;
        m_read          = '0;
        m_write         = '0;
        m_writedata     = '0;
        m_byteenable    = '0;
        m_burstcount    = '0;
        s_waitrequest   = 1'b0;
        s_readdata      = '0;
        s_readdatavalid = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        #2;
        chk("rst_waitreq", 64'(m_waitrequest), 64'h3);
        chk("rst_s_read", 64'(s_read), 64'h0);
        chk("rst_s_write", 64'(s_write), 64'h0);
        chk("rst_rdv", 64'(m_readdatavalid), 64'h0);
        chk("rst_err", 64'(err_unexp_rdv), 64'h0);
        chk("rst_state", 64'(arb_state), 64'(IDLE));
        cyc();
        cyc();
        reset = 1'b0;

        // Single write, burst 1
        m_write[0]        = 1'b1;
        m_address[0]      = 25'h0123;
        m_writedata[0]    = 64'hdead_beef_0000_0001;
        m_byteenable[0]   = 8'hff;
        m_burstcount[0]   = 3'd1;
        #2;
        chk("wr1_s_write", 64'(s_write), 64'h1);
        chk("wr1_addr", 64'(s_address), 64'h123);
        chk("wr1_data", s_writedata, 64'hdead_beef_0000_0001);
        chk("wr1_be", 64'(s_byteenable), 64'hff);
        chk("wr1_waitreq", 64'(m_waitrequest), 64'h2);
        cyc();
        m_write[0] = 1'b0;
        #2;
        chk("wr1_done_write", 64'(s_write), 64'h0);
        chk("wr1_state", 64'(arb_state), 64'(IDLE));
        chk("wr1_no_rdv", 64'(m_readdatavalid), 64'h0);

        // Alternating reads, burst 2 each
        do_reset();
        m_read          = 2'b11;
        m_address[0]    = 25'h100;
        m_address[1]    = 25'h200;
        m_burstcount[0] = 3'd2;
        m_burstcount[1] = 3'd2;
        for (int k = 0; k < 4; k++) begin
            #2;
            chk("rr_s_read", 64'(s_read), 64'h1);
            chk("rr_waitreq", 64'(m_waitrequest), (k % 2 == 0) ? 64'h2 : 64'h1);
            chk("rr_addr", 64'(s_address), (k % 2 == 0) ? 64'h100 : 64'h200);
            chk("rr_burst", 64'(s_burstcount), 64'h2);
            cyc();
        end
        m_read = 2'b00;
        for (int k = 0; k < 8; k++) begin
            s_readdatavalid = 1'b1;
            s_readdata      = 64'h5500 + 64'(k);
            #2;
            chk("rr_ret_rdv", 64'(m_readdatavalid), ((k / 2) % 2 == 0) ? 64'h1 : 64'h2);
            chk("rr_ret_data", m_readdata[k / 2 % 2], 64'h5500 + 64'(k));
            cyc();
        end
        s_readdatavalid = 1'b0;
        #2;
        chk("rr_ret_idle", 64'(m_readdatavalid), 64'h0);
        chk("rr_no_err", 64'(err_unexp_rdv), 64'h0);
        cyc();

        // Write burst 4 from M0 locks out M1's read
        m_write[0]      = 1'b1;
        m_address[0]    = 25'h40;
        m_burstcount[0] = 3'd4;
        m_read[1]       = 1'b1;
        m_address[1]    = 25'h80;
        m_burstcount[1] = 3'd1;
        for (int k = 0; k < 4; k++) begin
            m_writedata[0] = 64'hA000 + 64'(k);
            #2;
            chk("lock_s_write", 64'(s_write), 64'h1);
            chk("lock_s_read", 64'(s_read), 64'h0);
            chk("lock_waitreq", 64'(m_waitrequest), 64'h2);
            chk("lock_data", s_writedata, 64'hA000 + 64'(k));
            cyc();
            if (k == 1) begin
                m_write[0] = 1'b0;
                #2;
                chk("lock_gap_state", 64'(arb_state), 64'(WR_LOCK));
                chk("lock_gap_read", 64'(s_read), 64'h0);
                chk("lock_gap_waitreq1", 64'(m_waitrequest[1]), 64'h1);
                cyc();
                m_write[0] = 1'b1;
            end
        end
        m_write[0] = 1'b0;
        #2;
        chk("lock_release_state", 64'(arb_state), 64'(IDLE));
        chk("lock_m1_read", 64'(s_read), 64'h1);
        chk("lock_m1_waitreq", 64'(m_waitrequest), 64'h1);
        chk("lock_m1_addr", 64'(s_address), 64'h80);
        cyc();
        m_read = 2'b00;
        s_readdatavalid = 1'b1;
        s_readdata      = 64'h1111;
        #2;
        chk("lock_m1_ret", 64'(m_readdatavalid), 64'h2);
        cyc();
        s_readdatavalid = 1'b0;

        // Controller stall holds the granted read steady
        m_read          = 2'b11;
        m_address[0]    = 25'h300;
        m_address[1]    = 25'h400;
        m_burstcount[0] = 3'd1;
        m_burstcount[1] = 3'd1;
        s_waitrequest   = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #2;
            chk("stall_s_read", 64'(s_read), 64'h1);
            chk("stall_addr", 64'(s_address), 64'h300);
            chk("stall_waitreq", 64'(m_waitrequest), 64'h3);
            cyc();
        end
        s_waitrequest = 1'b0;
        #2;
        chk("stall_release_waitreq", 64'(m_waitrequest), 64'h2);
        chk("stall_release_addr", 64'(s_address), 64'h300);
        cyc();
        m_read = 2'b00;
        s_readdatavalid = 1'b1;
        #2;
        chk("stall_ret", 64'(m_readdatavalid), 64'h1);
        cyc();
        s_readdatavalid = 1'b0;

        // Fill the tracking FIFO; the 9th read stalls, a write still passes
        do_reset();
        m_read[0]       = 1'b1;
        m_address[0]    = 25'h10;
        m_burstcount[0] = 3'd1;
        for (int k = 0; k < 8; k++) begin
            #2;
            chk("fill_waitreq0", 64'(m_waitrequest[0]), 64'h0);
            cyc();
        end
        m_write[1]      = 1'b1;
        m_address[1]    = 25'h77;
        m_burstcount[1] = 3'd1;
        #2;
        chk("full_s_read", 64'(s_read), 64'h0);
        chk("full_s_write", 64'(s_write), 64'h1);
        chk("full_waitreq", 64'(m_waitrequest), 64'h1);
        chk("full_addr", 64'(s_address), 64'h77);
        cyc();
        m_write = 2'b00;
        m_read  = 2'b00;
        for (int k = 0; k < 8; k++) begin
            s_readdatavalid = 1'b1;
            #2;
            chk("drain_rdv", 64'(m_readdatavalid), 64'h1);
            cyc();
        end

        // Unexpected read beat with nothing outstanding
        #2;
        chk("unexp_rdv", 64'(m_readdatavalid), 64'h0);
        chk("unexp_err_before", 64'(err_unexp_rdv), 64'h0);
        cyc();
        s_readdatavalid = 1'b0;
        #2;
        chk("unexp_err_set", 64'(err_unexp_rdv), 64'h1);
        cyc();
        cyc();
        chk("unexp_err_sticky", 64'(err_unexp_rdv), 64'h1);

        // Asynchronous reset in the middle of a locked write burst
        m_write[0]      = 1'b1;
        m_address[0]    = 25'h55;
        m_burstcount[0] = 3'd4;
        #2;
        chk("mid_s_write", 64'(s_write), 64'h1);
        cyc();
        chk("mid_state_lock", 64'(arb_state), 64'(WR_LOCK));
        #2;
        reset = 1'b1;
        #1;
        chk("async_state", 64'(arb_state), 64'(IDLE));
        chk("async_s_write", 64'(s_write), 64'h0);
        chk("async_s_read", 64'(s_read), 64'h0);
        chk("async_waitreq", 64'(m_waitrequest), 64'h3);
        chk("async_err", 64'(err_unexp_rdv), 64'h0);
        chk("async_rdv", 64'(m_readdatavalid), 64'h0);
        cyc();
        reset = 1'b0;
        #2;
        chk("post_rst_write", 64'(s_write), 64'h1);
        chk("post_rst_waitreq", 64'(m_waitrequest), 64'h2);
        clear_inputs();
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
